mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory stage of the 16-bit pipelined core. Consumes the EX/MEM register outputs of the execute stage.
//  Drives the multi-cycle data memory through a Rd/Wr/Done handshake and stalls the upstream pipeline
//  while an access is outstanding. Produces the MEM/WB pipeline register, including the writeback mux.
//  Watchdog-times-out accesses that never complete.
// PARAMETERS
//  MAX_WAIT  16  cycles in WAIT without dmDone before timeout error (legal range 2..255)
// PORTS
//  clk          in   1   core clock
//  rst          in   1   asynchronous, active-low reset
//  aluOut       in   16  ALU result from EX; effective address for ld/st
//  reg2DataOut  in   16  store data
//  setVal       in   16  SEQ/SLT/SLE/SCO result
//  nextPcOut    in   16  PC+2 (JAL/JALR link value)
//  memEnOut     in   1   instruction accesses data memory
//  memWrtOut    in   1   access is a store (valid only with memEnOut)
//  regWrtOut    in   1   instruction writes the register file
//  regWrtSrcOut in   3   wb source: 0 alu, 1 mem, 2 setVal, 3 nextPc, 4-7 illegal
//  writeRegOut  in   3   destination register
//  haltOut      in   1   HALT reached this stage
//  err          in   1   error raised upstream
//  dmAddr       out  16  data memory address
//  dmWrData     out  16  data memory write data
//  dmRd         out  1   read request
//  dmWr         out  1   write request
//  dmRdData     in   16  read data; valid when dmDone=1
//  dmDone       in   1   access complete this cycle
//  memStall     out  1   freezes IF..EX/MEM registers
//  wbData       out  16  registered writeback value
//  regWrtWb     out  1   registered register-write enable
//  writeRegWb   out  3   registered destination
//  haltWb       out  1   registered halt
//  errWb        out  1   registered error (sticky after timeout)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, wait counter=0, all registered outputs 0. dmRd=dmWr=memStall=0.
//  - access = memEnOut & ~haltOut & ~aluOut[0] & ~err. A misaligned address (aluOut[0]=1 with memEnOut)
//    suppresses the access and sets errWb=1 on the next edge.
//  - dmAddr=aluOut and dmWrData=reg2DataOut (combinational pass-through).
//    dmRd = access & ~memWrtOut; dmWr = access & memWrtOut; both 0 in ERR.
//  - FSM IDLE:
//    - access & dmDone: single-cycle hit. memStall=0; MEM/WB captures at this edge; stay IDLE.
//    - access & ~dmDone: memStall=1; go to WAIT; counter=1.
//  - FSM WAIT:
//    - Request held asserted; inputs are stable because memStall freezes EX/MEM.
//    - memStall = ~dmDone.
//    - On dmDone: capture MEM/WB, return to IDLE, counter=0.
//    - Otherwise increment the counter. When counter==MAX_WAIT with no dmDone, go to ERR.
//  - FSM ERR: memStall=0, errWb=1, haltWb=1, regWrtWb=0; held until reset.
//  - MEM/WB update:
//    - Every edge with memStall=0 in IDLE/WAIT: wbData=mux(regWrtSrcOut); writeRegWb, haltWb pass through;
//      errWb = err | misaligned | illegal regWrtSrcOut (when regWrtOut=1).
//    - While memStall=1: insert a bubble (regWrtWb=0, haltWb=0, errWb=0) so WB never double-commits.
//  - Load latency: data appears on wbData exactly one edge after the cycle dmDone=1.
//  - Stores write no register unless regWrtOut (which is illegal; no special handling). wbData=aluOut for src 0.
//  - Simultaneous dmDone with the counter reaching MAX_WAIT: dmDone wins, no error.
//  - haltOut with memEnOut: no access is issued; halt propagates.
//  - Reset mid-WAIT: requests drop immediately (async), FSM returns to IDLE; the in-flight access is abandoned.
// TESTING
//  - Load hit: aluOut=16'h0040, memEnOut=1, regWrtSrcOut=1, dmDone=1 same cycle, dmRdData=16'hBEEF
//    -> memStall never 1; next edge wbData=BEEF, regWrtWb=1.
//  - Load miss: dmDone asserted 4 cycles after request -> memStall=1 for 4 cycles, dmRd held,
//    regWrtWb=0 during stall, wbData=dmRdData one edge after dmDone.
//  - Store miss: memWrtOut=1, reg2DataOut=16'h1234, dmDone after 2 cycles
//    -> dmWr=1 with dmWrData=1234 throughout; regWrtWb=0; memStall=1 for 2 cycles.
//  - Timeout: dmDone never asserted, MAX_WAIT=16 -> ERR after 16 WAIT cycles; memStall=0; errWb=haltWb=1 sticky.
//    Also dmDone on the 16th cycle -> no error.
//  - Misaligned: aluOut=16'h0041, memEnOut=1 -> dmRd=dmWr=0, no stall, errWb=1 next edge.
//  - Async reset asserted in WAIT -> dmRd drops before the next clk edge; all registered outputs 0; IDLE after release.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory stage of the 16-bit pipelined core: data-memory handshake, upstream stall,
// access watchdog and the MEM/WB pipeline register with its writeback mux.
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] aluOut,
    input  logic [15:0] reg2DataOut,
    input  logic [15:0] setVal,
    input  logic [15:0] nextPcOut,
    input  logic        memEnOut,
    input  logic        memWrtOut,
    input  logic        regWrtOut,
    input  logic [2:0]  regWrtSrcOut,
    input  logic [2:0]  writeRegOut,
    input  logic        haltOut,
    input  logic        err,
    output logic [15:0] dmAddr,
    output logic [15:0] dmWrData,
    output logic        dmRd,
    output logic        dmWr,
    input  logic [15:0] dmRdData,
    input  logic        dmDone,
    output logic        memStall,
    output logic [15:0] wbData,
    output logic        regWrtWb,
    output logic [2:0]  writeRegWb,
    output logic        haltWb,
    output logic        errWb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    state_t     state;
    logic [7:0] waitCnt;

    logic        access;
    logic        misaligned;
    logic        illegalSrc;
    logic        timeout;
    logic [15:0] wbNext;

    assign misaligned = memEnOut & aluOut[0];
    assign access     = memEnOut & ~haltOut & ~aluOut[0] & ~err;
    assign illegalSrc = regWrtOut & regWrtSrcOut[2];
    assign timeout    = (state == WAIT) & ~dmDone & (waitCnt == MAX_CNT);

    assign dmAddr   = aluOut;
    assign dmWrData = reg2DataOut;

    // NOTE: requests and stall are gated by rst so they drop the instant reset asserts,
    // without waiting for the state register to be observed on the next clock.
    always_comb begin
        dmRd     = 1'b0;
        dmWr     = 1'b0;
        memStall = 1'b0;
        if (rst && state != ERR) begin
            dmRd = access & ~memWrtOut;
            dmWr = access & memWrtOut;
            if (state == IDLE) memStall = access & ~dmDone;
            else               memStall = ~dmDone;
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wbNext = 16'h0000;
        case (regWrtSrcOut)
            3'd0:    wbNext = aluOut;
            3'd1:    wbNext = dmRdData;
            3'd2:    wbNext = setVal;
            3'd3:    wbNext = nextPcOut;
            default: wbNext = 16'h0000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            waitCnt    <= 8'd0;
            wbData     <= 16'h0000;
            regWrtWb   <= 1'b0;
            writeRegWb <= 3'd0;
            haltWb     <= 1'b0;
            errWb      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !dmDone) begin
                        state   <= WAIT;
                        waitCnt <= 8'd1;
                    end
                end
                WAIT: begin
                    if (dmDone) begin
                        state   <= IDLE;
                        waitCnt <= 8'd0;
                    end else if (waitCnt == MAX_CNT) begin
                        state <= ERR;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: state <= ERR;
            endcase

            // ERR freezes the pipeline in a halted, non-writing, flagged state until reset.
            if (state == ERR || timeout) begin
                regWrtWb <= 1'b0;
                haltWb   <= 1'b1;
                errWb    <= 1'b1;
            end else if (memStall) begin
                regWrtWb <= 1'b0;
                haltWb   <= 1'b0;
                errWb    <= 1'b0;
            end else begin
                wbData     <= wbNext;
                regWrtWb   <= regWrtOut;
                writeRegWb <= writeRegOut;
                haltWb     <= haltOut;
                errWb      <= err | misaligned | illegalSrc;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl: hits, misses, stores, writeback mux,
// misalignment, halt, watchdog boundary and asynchronous reset during an access.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] aluOut;
    logic [15:0] reg2DataOut;
    logic [15:0] setVal;
    logic [15:0] nextPcOut;
    logic        memEnOut;
    logic        memWrtOut;
    logic        regWrtOut;
    logic [2:0]  regWrtSrcOut;
    logic [2:0]  writeRegOut;
    logic        haltOut;
    logic        err;
    logic [15:0] dmAddr;
    logic [15:0] dmWrData;
    logic        dmRd;
    logic        dmWr;
    logic [15:0] dmRdData;
    logic        dmDone;
    logic        memStall;
    logic [15:0] wbData;
    logic        regWrtWb;
    logic [2:0]  writeRegWb;
    logic        haltWb;
    logic        errWb;

    int total = 0;
    int bad   = 0;

    mem_stage_ctrl #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .aluOut(aluOut), .reg2DataOut(reg2DataOut), .setVal(setVal), .nextPcOut(nextPcOut),
        .memEnOut(memEnOut), .memWrtOut(memWrtOut), .regWrtOut(regWrtOut),
        .regWrtSrcOut(regWrtSrcOut), .writeRegOut(writeRegOut), .haltOut(haltOut), .err(err),
        .dmAddr(dmAddr), .dmWrData(dmWrData), .dmRd(dmRd), .dmWr(dmWr),
        .dmRdData(dmRdData), .dmDone(dmDone), .memStall(memStall),
        .wbData(wbData), .regWrtWb(regWrtWb), .writeRegWb(writeRegWb),
        .haltWb(haltWb), .errWb(errWb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        aluOut = 16'h0000; reg2DataOut = 16'h0000; setVal = 16'h0000; nextPcOut = 16'h0000;
        memEnOut = 1'b0; memWrtOut = 1'b0; regWrtOut = 1'b0; regWrtSrcOut = 3'd0;
        writeRegOut = 3'd0; haltOut = 1'b0; err = 1'b0; dmRdData = 16'h0000; dmDone = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".wbData"},   wbData, 16'h0000);
        check({tag, ".regWrtWb"}, 16'(regWrtWb), 16'h0);
        check({tag, ".wrReg"},    16'(writeRegWb), 16'h0);
        check({tag, ".haltWb"},   16'(haltWb), 16'h0);
        check({tag, ".errWb"},    16'(errWb), 16'h0);
        check({tag, ".dmRd"},     16'(dmRd), 16'h0);
        check({tag, ".dmWr"},     16'(dmWr), 16'h0);
        check({tag, ".stall"},    16'(memStall), 16'h0);
    endtask

    task automatic loadReq(input logic [15:0] addr, input logic [2:0] rd);
        aluOut = addr; memEnOut = 1'b1; memWrtOut = 1'b0; regWrtOut = 1'b1;
        regWrtSrcOut = 3'd1; writeRegOut = rd; dmDone = 1'b0;
    endtask

    initial begin
        idleInputs();
        rst = 1'b0;
        #12;
        checkAllZero("reset");
        rst = 1'b1;
        tick();

        // Load hit: no stall, data one edge later.
        loadReq(16'h0040, 3'd3);
        dmDone = 1'b1; dmRdData = 16'hBEEF;
        #1;
        check("hit.dmRd", 16'(dmRd), 16'h1);
        check("hit.dmAddr", dmAddr, 16'h0040);
        check("hit.stall", 16'(memStall), 16'h0);
        tick();
        check("hit.wbData", wbData, 16'hBEEF);
        check("hit.regWrtWb", 16'(regWrtWb), 16'h1);
        check("hit.wrReg", 16'(writeRegWb), 16'h3);
        check("hit.errWb", 16'(errWb), 16'h0);

        // Load miss: done arrives 4 cycles after the request.
        loadReq(16'h0080, 3'd5);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("miss.stall", 16'(memStall), 16'h1);
            check("miss.dmRd", 16'(dmRd), 16'h1);
            tick();
            check("miss.bubble", 16'(regWrtWb), 16'h0);
        end
        dmDone = 1'b1; dmRdData = 16'hCAFE;
        #1;
        check("miss.doneStall", 16'(memStall), 16'h0);
        check("miss.doneRd", 16'(dmRd), 16'h1);
        tick();
        check("miss.wbData", wbData, 16'hCAFE);
        check("miss.regWrtWb", 16'(regWrtWb), 16'h1);
        check("miss.wrReg", 16'(writeRegWb), 16'h5);

        // Store miss: done after 2 cycles, no register write.
        idleInputs();
        aluOut = 16'h0100; memEnOut = 1'b1; memWrtOut = 1'b1; reg2DataOut = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("st.stall", 16'(memStall), 16'h1);
            check("st.dmWr", 16'(dmWr), 16'h1);
            check("st.dmRd", 16'(dmRd), 16'h0);
            check("st.wrData", dmWrData, 16'h1234);
            tick();
        end
        dmDone = 1'b1;
        #1;
        check("st.doneStall", 16'(memStall), 16'h0);
        check("st.doneWr", 16'(dmWr), 16'h1);
        tick();
        check("st.regWrtWb", 16'(regWrtWb), 16'h0);
        check("st.wbData", wbData, 16'h0100);

        // Writeback mux for non-memory instructions.
        idleInputs();
        regWrtOut = 1'b1; aluOut = 16'h1111; setVal = 16'h0001; nextPcOut = 16'h0202;
        dmRdData = 16'h7777; writeRegOut = 3'd6;
        regWrtSrcOut = 3'd0; tick(); check("mux.alu", wbData, 16'h1111);
        regWrtSrcOut = 3'd2; tick(); check("mux.set", wbData, 16'h0001);
        regWrtSrcOut = 3'd3; tick(); check("mux.pc", wbData, 16'h0202);
        check("mux.err", 16'(errWb), 16'h0);
        regWrtSrcOut = 3'd5; tick(); check("mux.illegal", 16'(errWb), 16'h1);
        err = 1'b1; regWrtSrcOut = 3'd0; tick(); check("mux.upErr", 16'(errWb), 16'h1);

        // Misaligned access: suppressed, flagged next edge, no stall.
        idleInputs();
        aluOut = 16'h0041; memEnOut = 1'b1;
        #1;
        check("mis.dmRd", 16'(dmRd), 16'h0);
        check("mis.dmWr", 16'(dmWr), 16'h0);
        check("mis.stall", 16'(memStall), 16'h0);
        tick();
        check("mis.errWb", 16'(errWb), 16'h1);
        idleInputs();
        tick();
        check("mis.clear", 16'(errWb), 16'h0);

        // Halt with a memory access: no request, halt propagates.
        aluOut = 16'h0040; memEnOut = 1'b1; haltOut = 1'b1;
        #1;
        check("halt.dmRd", 16'(dmRd), 16'h0);
        check("halt.stall", 16'(memStall), 16'h0);
        tick();
        check("halt.haltWb", 16'(haltWb), 16'h1);
        idleInputs();
        tick();

        // Watchdog boundary: done on the 16th WAIT cycle still completes cleanly.
        loadReq(16'h0200, 3'd2);
        for (int i = 0; i < 16; i++) tick();
        #1;
        check("wd16.stall", 16'(memStall), 16'h1);
        dmDone = 1'b1; dmRdData = 16'h5A5A;
        #1;
        check("wd16.doneStall", 16'(memStall), 16'h0);
        tick();
        check("wd16.errWb", 16'(errWb), 16'h0);
        check("wd16.haltWb", 16'(haltWb), 16'h0);
        check("wd16.wbData", wbData, 16'h5A5A);
        check("wd16.regWrtWb", 16'(regWrtWb), 16'h1);

        // Timeout: done never comes, ERR after 16 WAIT cycles.
        loadReq(16'h0300, 3'd4);
        for (int i = 0; i < 16; i++) tick();
        #1;
        check("to.lastStall", 16'(memStall), 16'h1);
        check("to.lastErr", 16'(errWb), 16'h0);
        tick();
        check("to.stall", 16'(memStall), 16'h0);
        check("to.dmRd", 16'(dmRd), 16'h0);
        check("to.errWb", 16'(errWb), 16'h1);
        check("to.haltWb", 16'(haltWb), 16'h1);
        check("to.regWrtWb", 16'(regWrtWb), 16'h0);
        idleInputs();
        regWrtOut = 1'b1; dmDone = 1'b1;
        tick(); tick();
        check("to.stickyErr", 16'(errWb), 16'h1);
        check("to.stickyHalt", 16'(haltWb), 16'h1);
        check("to.stickyWrt", 16'(regWrtWb), 16'h0);

        // Reset recovers from ERR; then async reset mid-WAIT abandons the access.
        idleInputs();
        rst = 1'b0; #2; rst = 1'b1;
        tick();
        check("rec.errWb", 16'(errWb), 16'h0);
        loadReq(16'h0400, 3'd1);
        tick(); tick();
        #1;
        check("rw.dmRd", 16'(dmRd), 16'h1);
        check("rw.stall", 16'(memStall), 16'h1);
        rst = 1'b0;
        #1;
        checkAllZero("rw");
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rw.idleStall", 16'(memStall), 16'h0);
        loadReq(16'h0500, 3'd7);
        dmDone = 1'b1; dmRdData = 16'h4321;
        #1;
        check("rw.hitStall", 16'(memStall), 16'h0);
        tick();
        check("rw.hitData", wbData, 16'h4321);
        check("rw.hitReg", 16'(writeRegWb), 16'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
